// File: rtl/count_seq_pkg.sv
// Shared encodings for the counter-sequencing arbiter: FSM states and
// counter direction constants.
package count_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/updown_counter.sv
// Plain up/down counter: steps by one in the selected direction when enabled,
// otherwise holds. The arbiter above guarantees it never steps past a target,
// so no saturation logic lives here.
module updown_counter
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // next value: +1 / -1 when enabled, hold otherwise
  always_comb begin
    count_d = count_q;
    if (en) begin
      if (mode == DIR_UP) count_d = count_q + WIDTH'(1);
      else                count_d = count_q - WIDTH'(1);
    end
  end

  // counter register, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/count_seq_arbiter.sv
// Round-robin arbiter that hands one shared up/down counter to one of two
// requesters at a time and walks the counter to that requester's target.
// The count value persists between jobs; each job starts where the last ended.
module count_seq_arbiter
  import count_seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int NREQ  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [WIDTH-1:0] tgt0,
  input  logic [WIDTH-1:0] tgt1,
  output logic [NREQ-1:0]  ack,
  output logic             grant_id,
  output logic             busy,
  output logic             done,
  output logic             mode,
  output logic             cnt_en,
  output logic [WIDTH-1:0] count
);

  state_e           state_q;
  logic             rr_q;      // requester that wins a tie next
  logic [WIDTH-1:0] tgt_q;     // latched target of the running job
  logic [NREQ-1:0]  ack_q;
  logic             gid_q;
  logic             busy_q;
  logic             done_q;

  logic             any_req;
  logic             win;
  logic [WIDTH-1:0] win_tgt;
  logic             mode_c;
  logic             en_c;
  logic [WIDTH-1:0] count_w;

  // round-robin pick: tie goes to rr_q, otherwise the lone requester wins
  always_comb begin
    any_req = |req;
    if (req[0] && req[1]) win = rr_q;
    else                  win = req[1];
    win_tgt = win ? tgt1 : tgt0;
  end

  // counter control only active in RUN; direction defaults to up elsewhere
  always_comb begin
    mode_c = DIR_UP;
    en_c   = 1'b0;
    if (state_q == ST_RUN) begin
      mode_c = (tgt_q > count_w) ? DIR_UP : DIR_DOWN;
      en_c   = (count_w != tgt_q);
    end
  end

  // job FSM with registered handshake outputs; ack/done are one-cycle pulses
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rr_q    <= 1'b0;
      tgt_q   <= '0;
      ack_q   <= '0;
      gid_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ack_q  <= '0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (any_req) begin
            ack_q   <= NREQ'(1) << win;
            tgt_q   <= win_tgt;
            gid_q   <= win;
            rr_q    <= ~win;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          // count == target (en_c low) ends the walk; zero-step jobs land here at once
          if (!en_c) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  updown_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (en_c),
    .mode  (mode_c),
    .count (count_w)
  );

  assign ack      = ack_q;
  assign grant_id = gid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mode     = mode_c;
  assign cnt_en   = en_c;
  assign count    = count_w;

endmodule
